// File: rtl/countdown_timer_bcd.sv
// rtl/countdown_timer_bcd.sv - MM:SS BCD countdown timer with expiry flag and done pulse (optional COUNTDOWN_AUTORELOAD_EN)
module countdown_timer_bcd #(
    parameter int MAX_MIN = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] preset_min,
    input  logic [7:0] preset_sec,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       expired,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

    state_t     state_q, state_d;
    logic [7:0] min_q, min_d, sec_q, sec_d;
    logic [7:0] dec_min, dec_sec;
    logic       dec_zero;
    logic [7:0] san_min, san_sec;
    logic       hit_zero;
    logic       running_d, expired_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [7:0] pre_min_q, pre_min_d, pre_sec_q, pre_sec_d;
`endif

    function automatic logic [3:0] clamp9(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    // Sanitise the preset: bad nibbles to 9, seconds to 59 max, minutes to MAX_MIN max
    always_comb begin
        logic [3:0] mt, mo, st, so;
        logic [6:0] min_val;
        mt      = clamp9(preset_min[7:4]);
        mo      = clamp9(preset_min[3:0]);
        st      = clamp9(preset_sec[7:4]);
        so      = clamp9(preset_sec[3:0]);
        min_val = {3'b000, mt} * 7'd10 + {3'b000, mo};
        san_min = (min_val > 7'(MAX_MIN)) ? {MAX_TENS, MAX_ONES} : {mt, mo};
        san_sec = (st > 4'd5) ? 8'h59 : {st, so};
    end

    // One-second BCD decrement with borrow chain; 00:00 holds rather than wrapping
    always_comb begin
        dec_min = min_q;
        dec_sec = sec_q;
        if (sec_q[3:0] != 4'd0) begin
            dec_sec[3:0] = sec_q[3:0] - 4'd1;
        end else if (sec_q[7:4] != 4'd0) begin
            dec_sec = {sec_q[7:4] - 4'd1, 4'd9};
        end else if (min_q != 8'h00) begin
            dec_sec = 8'h59;
            if (min_q[3:0] != 4'd0) begin
                dec_min[3:0] = min_q[3:0] - 4'd1;
            end else begin
                dec_min = {min_q[7:4] - 4'd1, 4'd9};
            end
        end
        dec_zero = (dec_min == 8'h00) && (dec_sec == 8'h00);
    end

    // State and count registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            min_q     <= 8'h00;
            sec_q     <= 8'h00;
`ifdef COUNTDOWN_AUTORELOAD_EN
            pre_min_q <= 8'h00;
            pre_sec_q <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
            pre_min_q <= pre_min_d;
            pre_sec_q <= pre_sec_d;
`endif
        end
    end

    // Next state and count, commands resolved clear > load > stop > start > tick
    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        sec_d     = sec_q;
        hit_zero  = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
        pre_min_d = pre_min_q;
        pre_sec_d = pre_sec_q;
`endif
        if (clear) begin
            state_d = IDLE;
            min_d   = 8'h00;
            sec_d   = 8'h00;
        end else if (load && state_q != RUN) begin
            state_d   = IDLE;
            min_d     = san_min;
            sec_d     = san_sec;
`ifdef COUNTDOWN_AUTORELOAD_EN
            pre_min_d = san_min;
            pre_sec_d = san_sec;
`endif
        end else if (stop && state_q == RUN) begin
            state_d = PAUSE;
        end else if (start && (state_q == IDLE || state_q == PAUSE) &&
                     (min_q != 8'h00 || sec_q != 8'h00)) begin
            state_d = RUN;
        end else if (tick && state_q == RUN) begin
            min_d = dec_min;
            sec_d = dec_sec;
            if (dec_zero) begin
                hit_zero = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                if (pre_min_q != 8'h00 || pre_sec_q != 8'h00) begin
                    min_d = pre_min_q;
                    sec_d = pre_sec_q;
                end else begin
                    state_d = EXPIRED;
                end
`else
                state_d = EXPIRED;
`endif
            end
        end
    end

    // Status flags follow the next state so they register on the same edge as the count
    always_comb begin
        running_d = (state_d == RUN);
        expired_d = (state_d == EXPIRED);
    end

    // Registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            expired <= 1'b0;
            done    <= 1'b0;
        end else begin
            running <= running_d;
            expired <= expired_d;
            done    <= hit_zero;
        end
    end

    assign min_bcd = min_q;
    assign sec_bcd = sec_q;

endmodule

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
- Minutes:seconds BCD countdown timer for the wall clock's kitchen/snooze timer function.
- Complements the free-running up counters: loads a preset, decrements once per tick strobe, and flags expiry to the alarm/buzzer logic.
- Outputs feed the display mux directly as BCD digit pairs.

Parameters:
- MAX_MIN, 99, largest accepted minutes preset (decimal; 1..99); larger presets clamp to this value.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- tick  input  1  one-cycle 1 Hz strobe from the prescaler
- load  input  1  latch preset_min/preset_sec into the count
- preset_min  input  8  BCD minutes preset {tens, ones}
- preset_sec  input  8  BCD seconds preset {tens, ones}
- start  input  1  begin or resume counting
- stop  input  1  pause counting
- clear  input  1  abort; count to 00:00, go IDLE
- min_bcd  output  8  current minutes, BCD
- sec_bcd  output  8  current seconds, BCD
- running  output  1  high while in RUN
- expired  output  1  high while in EXPIRED
- done  output  1  one-cycle pulse when the count reaches 00:00

Behaviour:
- Reset (async, active-high): state IDLE; min_bcd=0x00, sec_bcd=0x00, stored preset=00:00; running=0, expired=0, done=0.
- States: IDLE, RUN, PAUSE, EXPIRED. All outputs registered.
- Same-cycle command priority: clear > load > stop > start > tick.
- clear, any state: count=00:00, state=IDLE. The stored preset is kept.
- load, accepted in IDLE, PAUSE, EXPIRED; ignored in RUN:
  - count and stored preset take the sanitised preset; state=IDLE.
  - Sanitise: any BCD nibble >9 becomes 9; seconds >59 become 59; minutes >MAX_MIN become MAX_MIN.
- start, in IDLE or PAUSE with count≠00:00: go to RUN. Ignored when count=00:00 and in RUN or EXPIRED.
- stop, in RUN: go to PAUSE. A tick in the same cycle does not decrement.
- tick, in RUN: decrement by one second on that edge. Ignored in all other states.
  - sec ones 0→9 with borrow into sec tens.
  - sec 00→59 with borrow into minutes.
  - min ones 0→9 with borrow into min tens.
- Reaching zero: on the tick edge where the count becomes 00:00, state becomes EXPIRED and done=1 for exactly one cycle. running drops and expired rises on the same edge. Latency from tick to done is one clk.
- EXPIRED holds 00:00 until clear or load. Repeated ticks do not re-pulse done.
- Count never wraps below 00:00 and never holds a non-BCD value.
- Reset asserted mid-count aborts immediately to the reset values; no done pulse.

Optional Feature:
- Macro: COUNTDOWN_AUTORELOAD_EN.
- Defined: on reaching 00:00 in RUN, the count reloads the stored preset on the same edge and stays in RUN. done still pulses one cycle; expired stays 0. If the stored preset is 00:00, EXPIRED is entered as normal.
- Undefined: behaviour exactly as above, with no preset storage beyond load sanitising.

Test Plan:
- load 01:05, start, 65 ticks → values 01:04, 01:00, 00:59 … 00:00 in order; done high one cycle after the 65th tick; expired=1, running=0.
- load 0xA5:0x7C with MAX_MIN=99 → count 95:59 (min tens 0xA→9, ones 5 kept; sec 0x7C→59).
- RUN at 00:10, stop asserted with tick in the same cycle → PAUSE, count stays 00:10; start then 10 ticks → 00:00, done pulse.
- load asserted during RUN → ignored, counting continues; clear during RUN at 03:20 → 00:00, IDLE, no done pulse.
- Reset asserted mid-count at 12:34 between clock edges → outputs zero immediately, state IDLE.
- With COUNTDOWN_AUTORELOAD_EN: load 00:02, start, 4 ticks → 00:01, 02 (reload + done), 00:01, 02 (reload + done); expired stays 0, running stays 1.
